pattern_merge_pipe: RTL and testbench

- Parametrised successor to the two-pattern merged cells: a STAGES-deep chain of pattern stages, each an elastic valid/ready register slice.
- Each stage applies a selectable bitwise ring pattern (NAND, NOR, XOR, pass) to a WIDTH-bit word.
- Output side keeps a rolling signature register and a saturating accepted-word counter.
- Sits between pattern-merge datapaths as a generic, back-pressurable replacement for fixed two-stage merges.

---
 rtl/pattern_merge_pkg.sv | 46 ++++
 rtl/pattern_merge_stage.sv | 61 ++++++
 rtl/pattern_merge_pipe.sv | 105 ++++++++++
 tb/tb_pattern_merge_pipe.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_merge_pkg.sv
// ----------------------------------------------------------------------------
// pattern_merge_pkg
// Shared definitions for the pattern-merge pipeline:
//   pm_mode_e    - per-stage ring pattern selector
//   pm_apply     - ring pattern applied to a word of 'width' bits
//   pm_sig_next  - rolling signature update (rotate-left by one, then XOR)
// Functions work on PM_MAX_W-bit containers; callers zero-extend their word,
// pass their real width, and size-cast the result back.
// ----------------------------------------------------------------------------
package pattern_merge_pkg;

   localparam int PM_MAX_W = 64;

   typedef enum logic [1:0] {
      PM_NAND = 2'd0,
      PM_NOR  = 2'd1,
      PM_XOR  = 2'd2,
      PM_PASS = 2'd3
   } pm_mode_e;

   // y[i] = op(x[i], x[(i+1) mod width])
   function automatic logic [PM_MAX_W-1:0] pm_apply(input pm_mode_e               mode,
                                                     input logic [PM_MAX_W-1:0]    word,
                                                     input int                     width);
      logic [PM_MAX_W-1:0] w_nb;
      logic [PM_MAX_W-1:0] w_y;
      // Right shift lines up x[i+1] under x[i]; the top bit wraps to x[0].
      w_nb            = word >> 1;
      w_nb[width-1]   = word[0];
      case (mode)
         PM_NAND: w_y = ~(word & w_nb);
         PM_NOR:  w_y = ~(word | w_nb);
         PM_XOR:  w_y = word ^ w_nb;
         default: w_y = word;
      endcase
      return w_y;
   endfunction

   // sig' = rotl(sig, 1) ^ data; sig must be zero above 'width'.
   function automatic logic [PM_MAX_W-1:0] pm_sig_next(input logic [PM_MAX_W-1:0] sig,
                                                        input logic [PM_MAX_W-1:0] data,
                                                        input int                  width);
      return ((sig << 1) | (sig >> (width - 1))) ^ data;
   endfunction

endpackage

// File: rtl/pattern_merge_stage.sv
// ----------------------------------------------------------------------------
// pattern_merge_stage
// One elastic valid/ready register slice. On load it applies the ring pattern
// selected by i_mode[1:0] to the upstream word and keeps the remaining mode
// bits (shifted down by two) for the stages that follow.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_valid, i_data    upstream word
//   i_mode             modes still to be applied, this stage in bits [1:0]
//   o_ready            this slice can load (to upstream)
//   i_ready            downstream can accept
//   o_valid, o_data    registered word
//   o_mode             remaining modes travelling with the word
// ----------------------------------------------------------------------------
module pattern_merge_stage
   import pattern_merge_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MODE_W = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [WIDTH-1:0]  i_data,
   input  logic [MODE_W-1:0] i_mode,
   output logic              o_ready,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [WIDTH-1:0]  o_data,
   output logic [MODE_W-1:0] o_mode
);

   logic              r_valid;
   logic [WIDTH-1:0]  r_data;
   logic [MODE_W-1:0] r_mode;
   logic [WIDTH-1:0]  w_next_data;

   assign o_ready     = !r_valid || i_ready;
   assign w_next_data = WIDTH'(pm_apply(pm_mode_e'(i_mode[1:0]), PM_MAX_W'(i_data), WIDTH));

   // NOTE: state uses non-blocking assignments, and the data/mode registers are
   // reset too so an empty pipeline presents all-zero outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_mode  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= w_next_data;
            r_mode <= i_mode >> 2;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_mode  = r_mode;

endmodule

// File: rtl/pattern_merge_pipe.sv
// ----------------------------------------------------------------------------
// pattern_merge_pipe
// STAGES-deep chain of elastic pattern stages with an output-side rolling
// signature and saturating accepted-word counter.
// Ports:
//   blif_clk_net, blif_reset_net   clock, async active-low reset
//   in_valid/in_ready/in_data      input handshake (in_ready is combinational)
//   cfg_mode                       per-stage modes, captured with the word
//   out_valid/out_ready/out_data   output handshake (last stage register)
//   sig_clear                      synchronous clear of sig_out and word_cnt
//   sig_out, word_cnt              signature and saturating word count
//   busy                           any stage holds a word
// WIDTH must be in 2..64.
// ----------------------------------------------------------------------------
module pattern_merge_pipe
   import pattern_merge_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 3,
   parameter int CNT_W  = 16
) (
   input  logic                  blif_clk_net,
   input  logic                  blif_reset_net,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [2*STAGES-1:0]   cfg_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   input  logic                  sig_clear,
   output logic [WIDTH-1:0]      sig_out,
   output logic [CNT_W-1:0]      word_cnt,
   output logic                  busy
);

   localparam int MODE_W = 2 * STAGES;

   // Index s is the input side of stage s; index STAGES is the output side.
   logic              w_valid [0:STAGES];
   logic              w_ready [0:STAGES];
   logic [WIDTH-1:0]  w_data  [0:STAGES];
   logic [MODE_W-1:0] w_mode  [0:STAGES];

   logic [WIDTH-1:0]  r_sig;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_out_fire;

   assign w_valid[0]      = in_valid;
   assign w_data[0]       = in_data;
   assign w_mode[0]       = cfg_mode;
   assign w_ready[STAGES] = out_ready;
   assign in_ready        = w_ready[0];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      pattern_merge_stage #(
         .WIDTH  (WIDTH),
         .MODE_W (MODE_W)
      ) u_stage (
         .i_clk   (blif_clk_net),
         .i_rst_n (blif_reset_net),
         .i_valid (w_valid[s]),
         .i_data  (w_data[s]),
         .i_mode  (w_mode[s]),
         .o_ready (w_ready[s]),
         .i_ready (w_ready[s+1]),
         .o_valid (w_valid[s+1]),
         .o_data  (w_data[s+1]),
         .o_mode  (w_mode[s+1])
      );
   end

   assign out_valid  = w_valid[STAGES];
   assign out_data   = w_data[STAGES];
   assign w_out_fire = out_valid && out_ready;

   // NOTE: the default before the loop keeps this purely combinational (no latch).
   always_comb begin
      busy = 1'b0;
      for (int s = 1; s <= STAGES; s++) begin
         busy = busy | w_valid[s];
      end
   end

   // Clear has priority over a coincident handshake: that word is neither
   // hashed nor counted.
   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         r_sig <= '0;
         r_cnt <= '0;
      end else if (sig_clear) begin
         r_sig <= '0;
         r_cnt <= '0;
      end else if (w_out_fire) begin
         r_sig <= WIDTH'(pm_sig_next(PM_MAX_W'(r_sig), PM_MAX_W'(out_data), WIDTH));
         if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign sig_out  = r_sig;
   assign word_cnt = r_cnt;

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// ----------------------------------------------------------------------------
// tb_pattern_merge_pipe
// Directed scenarios plus randomized traffic for pattern_merge_pipe
// (WIDTH=8, STAGES=3, CNT_W=4). A negedge scoreboard keeps a queue of
// expected output words, the expected signature and the expected count,
// all computed from the bitwise ring rules.
// ----------------------------------------------------------------------------
module tb_pattern_merge_pipe;

   localparam int W  = 8;
   localparam int ST = 3;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_data;
   logic [2*ST-1:0]   cfg_mode;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic              sig_clear;
   logic [W-1:0]      sig_out;
   logic [CW-1:0]     word_cnt;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  sig_m;
   logic [CW-1:0] cnt_m;

   always #5 clk = ~clk;

   pattern_merge_pipe #(
      .WIDTH  (W),
      .STAGES (ST),
      .CNT_W  (CW)
   ) dut (
      .blif_clk_net   (clk),
      .blif_reset_net (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .cfg_mode       (cfg_mode),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .sig_clear      (sig_clear),
      .sig_out        (sig_out),
      .word_cnt       (word_cnt),
      .busy           (busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_stage(input int mode, input logic [W-1:0] x);
      logic [W-1:0] y;
      y = '0;
      for (int i = 0; i < W; i++) begin
         int j;
         j = (i + 1) % W;
         case (mode)
            0:       y[i] = !(x[i] && x[j]);
            1:       y[i] = !(x[i] || x[j]);
            2:       y[i] = (x[i] != x[j]);
            default: y[i] = x[i];
         endcase
      end
      return y;
   endfunction

   function automatic logic [W-1:0] model_pipe(input logic [W-1:0] d, input logic [2*ST-1:0] cfg);
      logic [W-1:0] x;
      x = d;
      for (int s = 0; s < ST; s++) begin
         x = model_stage(int'(cfg[2*s +: 2]), x);
      end
      return x;
   endfunction

   // Scoreboard: samples mid-cycle, i.e. the handshakes about to happen at
   // the next rising edge, and the state left by all previous edges.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst_n) begin
         exp_q.delete();
         sig_m = '0;
         cnt_m = '0;
      end else begin
         checks++;
         if (sig_out !== sig_m) begin
            failures++;
            $display("FAIL sb_sig got=%h exp=%h t=%0t", sig_out, sig_m, $time);
         end
         checks++;
         if (word_cnt !== cnt_m) begin
            failures++;
            $display("FAIL sb_cnt got=%0d exp=%0d t=%0t", word_cnt, cnt_m, $time);
         end
         checks++;
         if (busy !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL sb_busy got=%b exp=%b t=%0t", busy, exp_q.size() != 0, $time);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_extra_word got=%h exp=none t=%0t", out_data, $time);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  failures++;
                  $display("FAIL sb_data got=%h exp=%h t=%0t", out_data, e, $time);
               end
               if (!sig_clear) begin
                  sig_m = {sig_m[W-2:0], sig_m[W-1]} ^ e;
                  if (cnt_m != 4'd15) cnt_m = cnt_m + 4'd1;
               end
            end
         end
         if (sig_clear) begin
            sig_m = '0;
            cnt_m = '0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model_pipe(in_data, cfg_mode));
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      in_valid  = 1'b0;
      sig_clear = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_timeout got=busy exp=idle");
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_mode = '0;
      out_ready = 1'b0; sig_clear = 1'b0;
      #22;
      checks++;
      if ({out_valid, busy, out_data, sig_out, word_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%b/%h/%h/%0d exp=all zero",
                  out_valid, busy, out_data, sig_out, word_cnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_modes();
      logic [W-1:0]    d   [3] = '{8'hA5, 8'h01, 8'hFF};
      logic [2*ST-1:0] cfg [3] = '{6'b111111, 6'b111110, 6'b010000};
      logic [W-1:0]    ex  [3] = '{8'hA5, 8'h81, 8'h00};
      out_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         cfg_mode = cfg[t];
         in_data  = d[t];
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         cfg_mode = ~cfg[t];   // must not affect the word in flight
         for (int n = 0; n < 4; n++) begin
            checks++;
            if (out_valid !== (n == 2)) begin
               failures++;
               $display("FAIL mode%0d_valid_cyc%0d got=%b exp=%b", t, n, out_valid, n == 2);
            end
            if (n == 2) begin
               checks++;
               if (out_data !== ex[t]) begin
                  failures++;
                  $display("FAIL mode%0d_data got=%h exp=%h", t, out_data, ex[t]);
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_full();
      int k;
      cfg_mode  = 6'b111111;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         in_data = 8'h10 + 8'(k);
         #1;
         if (in_ready) k++;
         tick();
      end
      checks++;
      if (k !== 3) begin
         failures++;
         $display("FAIL full_accepted got=%0d exp=3", k);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_in_ready got=%b exp=0", in_ready);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_shift_ready got=%b exp=1", in_ready);
      end
      for (int n = 0; n < 4; n++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(n)) begin
            failures++;
            $display("FAIL full_order%0d got=%b/%h exp=1/%h", n, out_valid, out_data, 8'h10 + 8'(n));
         end
         tick();
         if (n == 0) in_valid = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_empty got=%b/%b/%b exp=0/0/1", out_valid, busy, in_ready);
      end
   endtask

   task automatic test_signature();
      out_ready = 1'b1; in_valid = 1'b0; cfg_mode = 6'b111111;
      sig_clear = 1'b1;
      tick();
      sig_clear = 1'b0;
      checks++;
      if (sig_out !== 8'h00 || word_cnt !== 4'd0) begin
         failures++;
         $display("FAIL sig_clear_idle got=%h/%0d exp=00/0", sig_out, word_cnt);
      end
      in_valid = 1'b1; in_data = 8'h01;
      tick();
      in_data = 8'h02;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (sig_out !== 8'h01 || word_cnt !== 4'd1) begin
         failures++;
         $display("FAIL sig_first got=%h/%0d exp=01/1", sig_out, word_cnt);
      end
      tick();
      checks++;
      if (sig_out !== 8'h00 || word_cnt !== 4'd2) begin
         failures++;
         $display("FAIL sig_second got=%h/%0d exp=00/2", sig_out, word_cnt);
      end
      in_valid = 1'b1; in_data = 8'h55;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL sig_third_present got=%b exp=1", out_valid);
      end
      sig_clear = 1'b1;
      tick();
      sig_clear = 1'b0;
      checks++;
      if (sig_out !== 8'h00 || word_cnt !== 4'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL sig_clear_wins got=%h/%0d/%b exp=00/0/0", sig_out, word_cnt, out_valid);
      end
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      sig_clear = 1'b1;
      tick();
      sig_clear = 1'b0;
      in_valid  = 1'b1;
      for (int n = 0; n < 20; n++) begin
         in_data  = 8'($urandom);
         cfg_mode = 6'($urandom);
         tick();
      end
      drain();
      checks++;
      if (word_cnt !== 4'd15) begin
         failures++;
         $display("FAIL saturate got=%0d exp=15", word_cnt);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 300; n++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_data   = 8'($urandom);
         cfg_mode  = 6'($urandom);
         out_ready = ($urandom_range(1) != 0);
         sig_clear = ($urandom_range(15) == 0);
         tick();
      end
      drain();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL random_lost got=%0d exp=0 words pending", exp_q.size());
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1; cfg_mode = 6'b111111;
      sig_clear = 1'b1;
      tick();
      sig_clear = 1'b0;
      in_valid = 1'b1; in_data = 8'h5A;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (sig_out !== 8'h5A || word_cnt !== 4'd1) begin
         failures++;
         $display("FAIL arst_pre_sig got=%h/%0d exp=5a/1", sig_out, word_cnt);
      end
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h11;
      tick();
      in_data = 8'h22;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL arst_pre_busy got=%b/%b exp=1/1", busy, out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, out_data, sig_out, word_cnt} !== '0) begin
         failures++;
         $display("FAIL arst_immediate got=%b/%b/%h/%h/%0d exp=all zero",
                  out_valid, busy, out_data, sig_out, word_cnt);
      end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL arst_release got=%b/%b exp=1/0", in_ready, busy);
      end
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h3C;
      tick();
      in_valid = 1'b0;
      drain();
      checks++;
      if (word_cnt !== 4'd1 || sig_out !== 8'h3C) begin
         failures++;
         $display("FAIL arst_no_replay got=%h/%0d exp=3c/1", sig_out, word_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_full();
      test_signature();
      test_saturate();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
